// File: rtl/inst_fetch_pkg.sv
// Shared configuration for the instruction fetch unit: widths, reset address, FSM encodings.
package inst_fetch_pkg;

  localparam int          INST_WIDTH       = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry {instruction, pc} holding register between fetch and decode.
// Outputs read as zero whenever the entry is empty; flush takes priority over load.
module fetch_out_buf
  import inst_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  ready,
  input  logic [INST_WIDTH-1:0] in_instr,
  input  logic [31:0]           in_pc,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] instr,
  output logic [31:0]           pc
);

  logic [INST_WIDTH-1:0] data_instr;
  logic [31:0]           data_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      data_instr <= '0;
      data_pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid      <= 1'b1;
      data_instr <= in_instr;
      data_pc    <= in_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign instr = valid ? data_instr : '0;
  assign pc    = valid ? data_pc    : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch FSM with one outstanding memory request and a one-entry decode buffer.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirect halts fetch and raises fetch_misaligned.
//
// state   | meaning
// ST_REQ  | presenting imem_addr=pc, waiting for acceptance
// ST_WAIT | one request in flight, waiting for its response
// ST_HALT | misaligned redirect seen; no requests until an aligned redirect
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INST_WIDTH-1:0] instruction_code,
  output logic [31:0]           inst_pc,
  output logic                  fetch_misaligned
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         bad_target;
  logic         drop;
  logic         accept;
  logic         load;
  logic         buf_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned;

  assign target     = redirect_pc;
  assign bad_target = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 misaligned <= 1'b0;
    else if (redirect_valid) misaligned <= bad_target;
  end

  assign fetch_misaligned = misaligned;
`else
  assign target           = redirect_pc & 32'hFFFF_FFFC;
  assign bad_target       = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign accept = imem_req_valid && imem_req_ready;
  // A response is only kept if it belongs to the current fetch stream.
  assign load   = (state == ST_WAIT) && imem_rsp_valid && !drop && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ: begin
        if (redirect_valid && bad_target) state_nxt = ST_HALT;
        else if (accept)                  state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect_valid && bad_target) state_nxt = ST_HALT;
        else if (imem_rsp_valid)          state_nxt = ST_REQ;
      end
      ST_HALT: begin
        if (redirect_valid && !bad_target) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && (state == ST_REQ) && (!buf_valid || dec_ready))
      imem_req_valid = 1'b1;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= target;
    else if (load)           pc <= pc + PC_STEP;
  end

  // drop marks an in-flight request orphaned by a redirect; it survives HALT
  // so a late response can never be mistaken for the restarted stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else begin
      case (state)
        ST_REQ:  if (accept && redirect_valid) drop <= 1'b1;
        ST_WAIT: begin
          if (imem_rsp_valid)      drop <= 1'b0;
          else if (redirect_valid) drop <= 1'b1;
        end
        ST_HALT: if (imem_rsp_valid) drop <= 1'b0;
        default: drop <= 1'b0;
      endcase
    end
  end

  fetch_out_buf u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (redirect_valid),
    .ready    (dec_ready),
    .in_instr (imem_rdata),
    .in_pc    (pc),
    .valid    (buf_valid),
    .instr    (instruction_code),
    .pc       (inst_pc)
  );

  assign dec_valid = buf_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: per-cycle vector table plus hand sequences for wrap, misalign and reset.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] instruction_code;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_addr        (imem_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rdata       (imem_rdata),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .instruction_code (instruction_code),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        drdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy, input logic rsp,
                     input logic [31:0] rdata, input logic drdy, input logic e_req,
                     input logic [31:0] e_addr, input logic e_dv, input logic [31:0] e_instr,
                     input logic [31:0] e_ipc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.drdy = drdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_dv = e_dv; v.e_instr = e_instr; v.e_ipc = e_ipc;
    vecs.push_back(v);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy, input logic rsp,
                       input logic [31:0] rdata, input logic drdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp;
    imem_rdata     = rdata;
    dec_ready      = drdy;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_dv, input logic [31:0] e_instr, input logic [31:0] e_ipc);
    chk1 ({tag, " req_valid"}, imem_req_valid, e_req);
    chk32({tag, " addr"}, imem_addr, e_addr);
    chk1 ({tag, " dec_valid"}, dec_valid, e_dv);
    chk32({tag, " instr"}, instruction_code, e_instr);
    chk32({tag, " inst_pc"}, inst_pc, e_ipc);
  endtask

  initial begin
    // cycle-by-cycle main stream: fetch, backpressure, redirects
    add(0,0,1,0,0,1,                 1,32'h0,  0,0,0);
    add(0,0,1,1,32'h13,1,            0,32'h0,  0,0,0);
    add(0,0,1,0,0,1,                 1,32'h4,  1,32'h13,32'h0);
    add(0,0,1,1,32'h13,1,            0,32'h4,  0,0,0);
    add(0,0,1,0,0,1,                 1,32'h8,  1,32'h13,32'h4);
    add(0,0,1,1,32'h00100093,0,      0,32'h8,  0,0,0);
    add(0,0,1,0,0,0,                 0,32'hC,  1,32'h00100093,32'h8);
    add(0,0,1,0,0,0,                 0,32'hC,  1,32'h00100093,32'h8);
    add(0,0,1,1,32'hDEADBEEF,0,      0,32'hC,  1,32'h00100093,32'h8);
    add(0,0,1,0,0,0,                 0,32'hC,  1,32'h00100093,32'h8);
    add(0,0,1,0,0,0,                 0,32'hC,  1,32'h00100093,32'h8);
    add(0,0,1,0,0,1,                 1,32'hC,  1,32'h00100093,32'h8);
    add(1,32'h100,1,0,0,1,           0,32'hC,  0,0,0);
    add(0,0,1,1,32'hBAD0BAD0,1,      0,32'h100,0,0,0);
    add(0,0,1,0,0,1,                 1,32'h100,0,0,0);
    add(0,0,1,1,32'h00200113,1,      0,32'h100,0,0,0);
    add(0,0,0,0,0,0,                 0,32'h104,1,32'h00200113,32'h100);
    add(1,32'h200,0,0,0,1,           1,32'h104,1,32'h00200113,32'h100);
    add(0,0,0,0,0,1,                 1,32'h200,0,0,0);
    add(0,0,1,0,0,1,                 1,32'h200,0,0,0);
    add(1,32'h300,1,1,32'h0000BEEF,1,0,32'h200,0,0,0);
    add(0,0,1,0,0,1,                 1,32'h300,0,0,0);
    add(0,0,1,1,32'h00300193,1,      0,32'h300,0,0,0);
    add(0,0,0,0,0,1,                 1,32'h304,1,32'h00300193,32'h300);
    add(1,32'h400,1,0,0,1,           1,32'h304,0,0,0);
    add(0,0,1,1,32'h0000DEAD,1,      0,32'h400,0,0,0);
    add(0,0,1,0,0,1,                 1,32'h400,0,0,0);
    add(0,0,1,1,32'h00400213,1,      0,32'h400,0,0,0);
    add(0,0,0,0,0,1,                 1,32'h404,1,32'h00400213,32'h400);

    // reset state, with inputs that would otherwise request
    drive(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk1("reset misaligned", fetch_misaligned, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].rsp, vecs[i].rdata, vecs[i].drdy);
      #1;
      chk_out($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_dv,
              vecs[i].e_instr, vecs[i].e_ipc);
      chk1($sformatf("row%0d misaligned", i), fetch_misaligned, 1'b0);
      step();
    end

    // pc wraps to zero after the last word
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 1); step();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk32("wrap addr", imem_addr, 32'hFFFF_FFFC);
    step();
    drive(0, 0, 0, 1, 32'h13, 1); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk_out("wrap", 1'b0, 32'h0, 1'b1, 32'h13, 32'hFFFF_FFFC);

`ifdef FETCH_MISALIGN_CHECK_EN
    drive(1, 32'h0000_0102, 0, 0, 0, 1); step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, 32'hBAD, 1); #1;
      chk1($sformatf("halt%0d misaligned", k), fetch_misaligned, 1'b1);
      chk1($sformatf("halt%0d req_valid", k), imem_req_valid, 1'b0);
      chk1($sformatf("halt%0d dec_valid", k), dec_valid, 1'b0);
      step();
    end
    drive(1, 32'h200, 0, 0, 0, 1); step();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk1("resume misaligned", fetch_misaligned, 1'b0);
    chk1("resume req_valid", imem_req_valid, 1'b1);
    chk32("resume addr", imem_addr, 32'h200);
    step();
    drive(0, 0, 0, 1, 32'h00500293, 1); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk_out("resume", 1'b0, 32'h204, 1'b1, 32'h00500293, 32'h200);
`else
    drive(1, 32'h0000_0102, 0, 0, 0, 1); step();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk1("align misaligned", fetch_misaligned, 1'b0);
    chk1("align req_valid", imem_req_valid, 1'b1);
    chk32("align addr", imem_addr, 32'h100);
    step();
    drive(0, 0, 0, 1, 32'h00500293, 1); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk_out("align", 1'b0, 32'h104, 1'b1, 32'h00500293, 32'h100);
`endif

    // reset asserted while a request is in flight; stale response after release
    drive(1, 32'h40, 0, 0, 0, 1); step();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk32("rstwait addr", imem_addr, 32'h40);
    step();
    drive(0, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_out("in reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 1, 32'hBAD, 1); #1;
    chk_out("post reset", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    drive(0, 0, 1, 0, 0, 1); #1;
    chk_out("stale ignored", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    drive(0, 0, 0, 1, 32'h13, 1); step();
    drive(0, 0, 0, 0, 0, 0); #1;
    chk_out("refetch", 1'b0, 32'h4, 1'b1, 32'h13, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
